// File: rtl/rs_pop_sched.sv
// Read-out scheduler behind the RS decoder FIFO: pops codeword bursts, pairs
// 64-bit words into sync-tagged 128-bit blocks and serves them FWFT on valid/ready.
module rs_pop_sched #(
  parameter int WORDS_PER_CW = 24,
  parameter int OFIFO_DEPTH  = 16,
  parameter int MAX_PEND     = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cw_done,
  output logic         pop_data_ena,
  input  logic         rs_pop_data_vld,
  input  logic [63:0]  rs_pop_data,
  input  logic         rs_pop_isos,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [127:0] out_data,
  output logic         out_sync,
  output logic         out_last,
  output logic         sync_err,
  output logic         pend_ovf,
  input  logic         err_clr
);

  localparam int HALF = WORDS_PER_CW / 2;
  localparam int AW   = $clog2(OFIFO_DEPTH);
  localparam int PTRW = AW + 1;
  localparam int BW   = (WORDS_PER_CW > 1) ? $clog2(WORDS_PER_CW) : 1;
  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [BW-1:0]   LAST_BEAT = BW'(WORDS_PER_CW - 1);
  localparam logic [KW-1:0]   LAST_PAIR = KW'(HALF - 1);
  localparam logic [PW-1:0]   PEND_MAX  = PW'(MAX_PEND);
  localparam logic [PTRW-1:0] DEPTH_W   = PTRW'(OFIFO_DEPTH);
  localparam logic [PTRW-1:0] HALF_W    = PTRW'(HALF);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

  typedef struct packed {
    logic         last;
    logic         sync;
    logic [127:0] data;
  } blk_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            gap_q, gap_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            widx_q, widx_d;
  logic [63:0]     hold_data_q, hold_data_d;
  logic            hold_isos_q, hold_isos_d;
  logic [KW-1:0]   pair_q, pair_d;
  logic            sync_err_q, sync_err_d;
  logic            pend_ovf_q, pend_ovf_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  blk_t            mem_q [OFIFO_DEPTH];

  logic [PTRW-1:0] count;
  logic [PTRW-1:0] free;
  logic            empty, full, room;
  logic            cw_acc, can_start, start;
  logic            pair_wr, fifo_rd;
  blk_t            wr_blk, head;

  assign count     = wptr_q - rptr_q;
  assign free      = DEPTH_W - count;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_W);
  assign room      = (free >= HALF_W);
  assign cw_acc    = cw_done && (pend_q != PEND_MAX);
  // A same-cycle cw_done counts as pending so the burst starts on the next cycle.
  assign can_start = ((pend_q != '0) || cw_done) && room;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          start   = 1'b1;
          state_d = S_POP;
          beat_d  = '0;
        end
      end
      S_POP: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = S_GAP;
          beat_d  = '0;
          gap_d   = 1'b0;
        end
      end
      S_GAP: begin
        gap_d = 1'b1;
        // Second gap cycle may launch the next burst directly (spacing WORDS_PER_CW+2).
        if (gap_q) begin
          if (can_start) begin
            start   = 1'b1;
            state_d = S_POP;
            beat_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop_data_ena = (state_q == S_POP);

  always_comb begin
    pend_d = pend_q;
    if (cw_acc && !start) begin
      pend_d = pend_q + 1'b1;
    end else if (!cw_acc && start) begin
      pend_d = pend_q - 1'b1;
    end
  end

  assign pair_wr = rs_pop_data_vld && widx_q;

  always_comb begin
    widx_d      = widx_q;
    pair_d      = pair_q;
    hold_data_d = hold_data_q;
    hold_isos_d = hold_isos_q;
    if (start) begin
      widx_d = 1'b0;
      pair_d = '0;
    end else if (rs_pop_data_vld) begin
      widx_d = !widx_q;
      if (!widx_q) begin
        hold_data_d = rs_pop_data;
        hold_isos_d = rs_pop_isos;
      end else begin
        pair_d = (pair_q == LAST_PAIR) ? '0 : pair_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_blk.last = (pair_q == LAST_PAIR);
    wr_blk.sync = rs_pop_isos;
    wr_blk.data = {hold_data_q, rs_pop_data};
  end

  always_comb begin
    sync_err_d = sync_err_q;
    pend_ovf_d = pend_ovf_q;
    if (err_clr) begin
      sync_err_d = 1'b0;
      pend_ovf_d = 1'b0;
    end else begin
      if (pair_wr && (hold_isos_q != rs_pop_isos)) sync_err_d = 1'b1;
      if (cw_done && (pend_q == PEND_MAX))         pend_ovf_d = 1'b1;
    end
  end

  assign fifo_rd = !empty && out_rdy;
  assign wptr_d  = wptr_q + PTRW'(pair_wr);
  assign rptr_d  = rptr_q + PTRW'(fifo_rd);
  assign head    = mem_q[rptr_q[AW-1:0]];

  assign out_vld  = !empty;
  assign out_data = empty ? '0 : head.data;
  assign out_sync = !empty && head.sync;
  assign out_last = !empty && head.last;
  assign sync_err = sync_err_q;
  assign pend_ovf = pend_ovf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      gap_q       <= 1'b0;
      pend_q      <= '0;
      widx_q      <= 1'b0;
      hold_data_q <= '0;
      hold_isos_q <= 1'b0;
      pair_q      <= '0;
      sync_err_q  <= 1'b0;
      pend_ovf_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      pend_q      <= pend_d;
      widx_q      <= widx_d;
      hold_data_q <= hold_data_d;
      hold_isos_q <= hold_isos_d;
      pair_q      <= pair_d;
      sync_err_q  <= sync_err_d;
      pend_ovf_q  <= pend_ovf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pair_wr) mem_q[wptr_q[AW-1:0]] <= wr_blk;
  end

  a_no_ofifo_overflow: assert property (@(posedge clk) disable iff (!rstn) pair_wr |-> !full);

endmodule

// File: tb/tb_rs_pop_sched.sv
// Bench for rs_pop_sched: upstream FIFO model with random words, block stream
// predicted by pairing the popped words, plus cycle-exact burst/flag checks.
`timescale 1ns/1ps
module tb_rs_pop_sched;
  localparam int W    = 24;
  localparam int HALF = W / 2;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cw_done = 1'b0;
  logic         pop_data_ena;
  logic         rs_pop_data_vld = 1'b0;
  logic [63:0]  rs_pop_data = '0;
  logic         rs_pop_isos = 1'b0;
  logic         out_rdy = 1'b0;
  logic         out_vld;
  logic [127:0] out_data;
  logic         out_sync;
  logic         out_last;
  logic         sync_err;
  logic         pend_ovf;
  logic         err_clr = 1'b0;

  rs_pop_sched #(.WORDS_PER_CW(W), .OFIFO_DEPTH(16), .MAX_PEND(2)) dut (
    .clk(clk), .rstn(rstn), .cw_done(cw_done), .pop_data_ena(pop_data_ena),
    .rs_pop_data_vld(rs_pop_data_vld), .rs_pop_data(rs_pop_data), .rs_pop_isos(rs_pop_isos),
    .out_rdy(out_rdy), .out_vld(out_vld), .out_data(out_data), .out_sync(out_sync),
    .out_last(out_last), .sync_err(sync_err), .pend_ovf(pend_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         sync;
    logic         last;
    int           cyc;
  } rx_t;

  rx_t         rx[$];
  logic [64:0] upq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          widx = 0;
  logic        ena_hist [MAXC];
  logic        serr_hist [MAXC];
  bit          mm_en = 1'b0;
  logic        pair_isos = 1'b0;

  // One clock: sample this cycle, advance, then act as the upstream FIFO.
  task automatic tick();
    logic ena_now;
    rx_t  r;
    ena_now = pop_data_ena;
    if (cyc < MAXC) begin
      ena_hist[cyc]  = pop_data_ena;
      serr_hist[cyc] = sync_err;
    end
    if (out_vld && out_rdy && rstn) begin
      r.data = out_data; r.sync = out_sync; r.last = out_last; r.cyc = cyc;
      rx.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
    cw_done = 1'b0;
    err_clr = 1'b0;
    rs_pop_data = {$urandom, $urandom};
    rs_pop_data_vld = ena_now;
    if (ena_now) begin
      if (widx % 2 == 0) pair_isos = 1'($urandom);
      rs_pop_isos = pair_isos;
      if (mm_en && (widx == 6 || widx == 10)) rs_pop_isos = 1'b1;
      if (mm_en && (widx == 7 || widx == 11)) rs_pop_isos = 1'b0;
      upq.push_back({rs_pop_isos, rs_pop_data});
      widx = (widx + 1) % W;
    end else begin
      rs_pop_isos = 1'($urandom);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; cw_done = 1'b0; err_clr = 1'b0; out_rdy = 1'b0; mm_en = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    upq.delete(); rx.delete(); widx = 0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    tick(); tick();
    checks++; if (pop_data_ena !== 1'b0) begin errors++; $display("FAIL rst_ena got %b want 0", pop_data_ena); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", out_vld); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
    checks++; if (out_sync !== 1'b0) begin errors++; $display("FAIL rst_sync got %b want 0", out_sync); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", out_last); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_serr got %b want 0", sync_err); end
    checks++; if (pend_ovf !== 1'b0) begin errors++; $display("FAIL rst_povf got %b want 0", pend_ovf); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cd; logic e; logic [64:0] a, b;
    do_reset();
    out_rdy = 1'b1; cw_done = 1'b1; cd = cyc;
    run(40);
    for (int c = cd; c < cd + 40; c++) begin
      e = (c >= cd + 1 && c <= cd + W);
      checks++; if (ena_hist[c] !== e) begin errors++; $display("FAIL single_ena cyc+%0d got %b want %b", c - cd, ena_hist[c], e); end
    end
    checks++; if (rx.size() != HALF) begin errors++; $display("FAIL single_count got %0d want %0d", rx.size(), HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k == HALF - 1)) begin
        errors++; $display("FAIL single_blk%0d got %h/%b/%b want %h/%b/%b", k, rx[k].data, rx[k].sync, rx[k].last, {a[63:0], b[63:0]}, b[64], (k == HALF - 1));
      end
      checks++; if (rx[k].cyc != cd + 4 + 2 * k) begin errors++; $display("FAIL single_time%0d got +%0d want +%0d", k, rx[k].cyc - cd, 4 + 2 * k); end
    end
  endtask

  task automatic test_two();
    int cd; logic e; logic [64:0] a, b;
    do_reset();
    out_rdy = 1'b1; cw_done = 1'b1; cd = cyc;
    run(3);
    cw_done = 1'b1;
    run(80);
    for (int c = cd; c < cd + 83; c++) begin
      e = (c >= cd + 1 && c <= cd + W) || (c >= cd + W + 3 && c <= cd + 2 * W + 2);
      checks++; if (ena_hist[c] !== e) begin errors++; $display("FAIL two_ena cyc+%0d got %b want %b", c - cd, ena_hist[c], e); end
    end
    checks++; if (rx.size() != 2 * HALF) begin errors++; $display("FAIL two_count got %0d want %0d", rx.size(), 2 * HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k % HALF == HALF - 1)) begin
        errors++; $display("FAIL two_blk%0d got %h/%b/%b want %h/%b", k, rx[k].data, rx[k].sync, rx[k].last, {a[63:0], b[63:0]}, b[64]);
      end
    end
  endtask

  task automatic test_overflow();
    int cd, p1; logic [64:0] a, b;
    do_reset();
    out_rdy = 1'b0; cw_done = 1'b1; cd = cyc;
    run(40);
    out_rdy = 1'b1; run(7); out_rdy = 1'b0;
    p1 = cyc;
    cw_done = 1'b1; run(2);
    cw_done = 1'b1; run(2);
    checks++; if (pend_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", pend_ovf); end
    cw_done = 1'b1; tick();
    checks++; if (pend_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", pend_ovf); end
    run(20);
    for (int c = p1; c < cyc; c++) begin
      checks++; if (ena_hist[c] !== 1'b0) begin errors++; $display("FAIL ovf_noburst cyc+%0d got %b want 0", c - p1, ena_hist[c]); end
    end
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    checks++; if (pop_data_ena !== 1'b0) begin errors++; $display("FAIL ovf_release0 got %b want 0", pop_data_ena); end
    tick();
    checks++; if (pop_data_ena !== 1'b1) begin errors++; $display("FAIL ovf_release1 got %b want 1", pop_data_ena); end
    run(40);
    out_rdy = 1'b1;
    run(120);
    checks++; if (upq.size() != 3 * W) begin errors++; $display("FAIL ovf_words got %0d want %0d", upq.size(), 3 * W); end
    checks++; if (rx.size() != 3 * HALF) begin errors++; $display("FAIL ovf_blocks got %0d want %0d", rx.size(), 3 * HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k % HALF == HALF - 1)) begin
        errors++; $display("FAIL ovf_blk%0d got %h/%b/%b want %h/%b", k, rx[k].data, rx[k].sync, rx[k].last, {a[63:0], b[63:0]}, b[64]);
      end
    end
    checks++; if (pend_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", pend_ovf); end
    err_clr = 1'b1; tick();
    checks++; if (pend_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", pend_ovf); end
  endtask

  task automatic test_isos();
    int cd; logic [64:0] a, b;
    do_reset();
    out_rdy = 1'b1; mm_en = 1'b1; cw_done = 1'b1; cd = cyc;
    for (int i = 0; i < 40; i++) begin
      if (cyc == cd + 13) err_clr = 1'b1;
      tick();
    end
    mm_en = 1'b0;
    checks++; if (serr_hist[cd+9]  !== 1'b0) begin errors++; $display("FAIL isos_pre got %b want 0", serr_hist[cd+9]); end
    checks++; if (serr_hist[cd+10] !== 1'b1) begin errors++; $display("FAIL isos_set got %b want 1", serr_hist[cd+10]); end
    checks++; if (serr_hist[cd+13] !== 1'b1) begin errors++; $display("FAIL isos_hold got %b want 1", serr_hist[cd+13]); end
    checks++; if (serr_hist[cd+14] !== 1'b0) begin errors++; $display("FAIL isos_clr_prio got %b want 0", serr_hist[cd+14]); end
    checks++; if (serr_hist[cd+16] !== 1'b0) begin errors++; $display("FAIL isos_after got %b want 0", serr_hist[cd+16]); end
    checks++; if (rx.size() != HALF) begin errors++; $display("FAIL isos_count got %0d want %0d", rx.size(), HALF); end
    if (rx.size() > 5) begin
      checks++; if (rx[3].sync !== 1'b0) begin errors++; $display("FAIL isos_blk3_sync got %b want 0", rx[3].sync); end
    end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k == HALF - 1)) begin
        errors++; $display("FAIL isos_blk%0d got %h/%b want %h/%b", k, rx[k].data, rx[k].sync, {a[63:0], b[63:0]}, b[64]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cd; logic [64:0] a, b;
    do_reset();
    out_rdy = 1'b0; cw_done = 1'b1; cd = cyc;
    run(11);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mid_prevld got %b want 1", out_vld); end
    rstn = 1'b0; #1;
    checks++; if (pop_data_ena !== 1'b0) begin errors++; $display("FAIL mid_ena got %b want 0", pop_data_ena); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_vld got %b want 0", out_vld); end
    tick(); tick();
    rstn = 1'b1;
    upq.delete(); rx.delete(); widx = 0;
    tick();
    out_rdy = 1'b1; cw_done = 1'b1; cd = cyc;
    run(40);
    checks++; if (rx.size() != HALF) begin errors++; $display("FAIL mid_count got %0d want %0d", rx.size(), HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k == HALF - 1) || rx[k].cyc != cd + 4 + 2 * k) begin
        errors++; $display("FAIL mid_blk%0d got %h/%b/%b @+%0d want %h/%b", k, rx[k].data, rx[k].sync, rx[k].last, rx[k].cyc - cd, {a[63:0], b[63:0]}, b[64]);
      end
    end
  endtask

  task automatic test_throttle();
    logic hold; logic [127:0] hd; logic [64:0] a, b;
    do_reset();
    cw_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      out_rdy = (i % 2 == 0);
      hold = out_vld && !out_rdy;
      hd = out_data;
      tick();
      if (hold) begin
        checks++; if (out_vld !== 1'b1 || out_data !== hd) begin errors++; $display("FAIL thr_stable i%0d got %b/%h want 1/%h", i, out_vld, out_data, hd); end
      end
    end
    out_rdy = 1'b1; run(10);
    checks++; if (rx.size() != HALF) begin errors++; $display("FAIL thr_count got %0d want %0d", rx.size(), HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k == HALF - 1)) begin
        errors++; $display("FAIL thr_blk%0d got %h/%b want %h/%b", k, rx[k].data, rx[k].sync, {a[63:0], b[63:0]}, b[64]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] a, b;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      cw_done = 1'b1;
      for (int i = 0; i < 30; i++) begin
        out_rdy = ($urandom % 4) != 0;
        tick();
      end
    end
    out_rdy = 1'b1; run(150);
    checks++; if (upq.size() != 4 * W) begin errors++; $display("FAIL b2b_words got %0d want %0d", upq.size(), 4 * W); end
    checks++; if (rx.size() != 4 * HALF) begin errors++; $display("FAIL b2b_blocks got %0d want %0d", rx.size(), 4 * HALF); end
    for (int k = 0; k < rx.size() && 2 * k + 1 < upq.size(); k++) begin
      a = upq[2*k]; b = upq[2*k+1];
      checks++;
      if (rx[k].data !== {a[63:0], b[63:0]} || rx[k].sync !== b[64] || rx[k].last !== (k % HALF == HALF - 1)) begin
        errors++; $display("FAIL b2b_blk%0d got %h/%b/%b want %h/%b", k, rx[k].data, rx[k].sync, rx[k].last, {a[63:0], b[63:0]}, b[64]);
      end
    end
    checks++; if (sync_err !== 1'b0 || pend_ovf !== 1'b0) begin errors++; $display("FAIL b2b_flags got %b/%b want 0/0", sync_err, pend_ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_overflow();
    test_isos();
    test_reset_mid();
    test_throttle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
